// File: rtl/riscv_pkg.sv
// Shared definitions for the memory stage: funct3 codes, LSU state encoding
// and the access-size decode used by both the LSU and the load aligner.
package riscv_pkg;

   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;
   localparam logic [2:0] F3_SB  = 3'b000;
   localparam logic [2:0] F3_SH  = 3'b001;
   localparam logic [2:0] F3_SW  = 3'b010;

   typedef enum logic [1:0] {LSU_IDLE, LSU_REQ, LSU_DONE} lsu_state_t;
   typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} lsu_size_t;

   // Any funct3 that is not a legal B/H encoding for the direction is a word access.
   function automatic lsu_size_t lsu_size(input logic [2:0] f3, input logic is_store);
      lsu_size_t sz;
      sz = SZ_W;
      if (f3 == F3_SB || (!is_store && f3 == F3_LBU)) begin
         sz = SZ_B;
      end else if (f3 == F3_SH || (!is_store && f3 == F3_LHU)) begin
         sz = SZ_H;
      end
      return sz;
   endfunction

endpackage

// File: rtl/load_align.sv
// Selects the addressed byte/halfword from a read word and sign- or
// zero-extends it according to funct3.
module load_align
   import riscv_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [XLEN-1:0] word,
   input  logic [1:0]      offset,
   input  logic [2:0]      funct3,
   output logic [XLEN-1:0] data
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   always_comb begin
      byte_sel = word[{offset, 3'b000} +: 8];
      half_sel = word[{offset[1], 4'b0000} +: 16];
      data     = word;
      case (lsu_size(funct3, 1'b0))
         SZ_B:    data = {{(XLEN-8){byte_sel[7] & ~funct3[2]}}, byte_sel};
         SZ_H:    data = {{(XLEN-16){half_sel[15] & ~funct3[2]}}, half_sel};
         default: data = word;
      endcase
   end

endmodule

// File: rtl/load_store_unit.sv
// Memory-stage load/store controller: launches one req/ack bus access per
// load/store, stalls the pipeline until it completes, and pulses 'loaded'.
module load_store_unit
   import riscv_pkg::*;
#(
   parameter int XLEN        = 32,
   parameter int ACK_TIMEOUT = 255
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            mem_read,
   input  logic            mem_write,
   input  logic [2:0]      funct3,
   input  logic [XLEN-1:0] addr,
   input  logic [XLEN-1:0] wdata,
   output logic            loaded,
   output logic            mem_stall,
   output logic [XLEN-1:0] rdata,
   output logic            misaligned,
   output logic            bus_err,
   output logic            dmem_req,
   output logic            dmem_we,
   output logic [XLEN-1:0] dmem_addr,
   output logic [XLEN-1:0] dmem_wdata,
   output logic [3:0]      dmem_mask,
   input  logic            dmem_ack,
   input  logic [XLEN-1:0] dmem_rdata
);

   localparam int CNT_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((ACK_TIMEOUT > 0) ? ACK_TIMEOUT - 1 : 0);

   lsu_state_t       state_q, state_d;
   logic             req_q, req_d, we_q, we_d;
   logic             loaded_q, loaded_d, mis_q, mis_d, err_q, err_d;
   logic [XLEN-1:0]  addr_q, addr_d, wdata_q, wdata_d, word_q, word_d;
   logic [3:0]       mask_q, mask_d;
   logic [1:0]       off_q, off_d;
   logic [2:0]       f3_q, f3_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   logic             access, aligned, timeout;
   lsu_size_t        size;
   logic [3:0]       st_mask;
   logic [XLEN-1:0]  st_lanes;

   assign access  = mem_read | mem_write;
   assign size    = lsu_size(funct3, mem_write);
   assign timeout = (ACK_TIMEOUT != 0) && (cnt_q == CNT_LAST);

   always_comb begin
      aligned  = 1'b1;
      st_mask  = 4'b1111;
      st_lanes = wdata;
      case (size)
         SZ_B: begin
            st_mask  = 4'b0001 << addr[1:0];
            st_lanes = {4{wdata[7:0]}};
         end
         SZ_H: begin
            aligned  = ~addr[0];
            st_mask  = addr[1] ? 4'b1100 : 4'b0011;
            st_lanes = {2{wdata[15:0]}};
         end
         default: aligned = (addr[1:0] == 2'b00);
      endcase
   end

   always_comb begin
      state_d  = state_q;
      req_d    = req_q;
      we_d     = we_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      mask_d   = mask_q;
      off_d    = off_q;
      f3_d     = f3_q;
      word_d   = word_q;
      cnt_d    = cnt_q;
      loaded_d = 1'b0;
      mis_d    = 1'b0;
      err_d    = 1'b0;
      case (state_q)
         LSU_IDLE: begin
            if (access) begin
               off_d  = addr[1:0];
               f3_d   = funct3;
               word_d = '0;
               if (aligned) begin
                  state_d = LSU_REQ;
                  req_d   = 1'b1;
                  cnt_d   = '0;
                  we_d    = mem_write;
                  addr_d  = {addr[XLEN-1:2], 2'b00};
                  wdata_d = mem_write ? st_lanes : '0;
                  mask_d  = mem_write ? st_mask : 4'b1111;
               end else begin
                  state_d  = LSU_DONE;
                  loaded_d = 1'b1;
                  mis_d    = 1'b1;
               end
            end
         end
         LSU_REQ: begin
            if (dmem_ack) begin
               state_d  = LSU_DONE;
               req_d    = 1'b0;
               loaded_d = 1'b1;
               word_d   = we_q ? '0 : dmem_rdata;
            end else if (timeout) begin
               state_d  = LSU_DONE;
               req_d    = 1'b0;
               loaded_d = 1'b1;
               err_d    = 1'b1;
               word_d   = '0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: state_d = LSU_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= LSU_IDLE;
         req_q    <= 1'b0;
         we_q     <= 1'b0;
         addr_q   <= '0;
         wdata_q  <= '0;
         mask_q   <= '0;
         off_q    <= '0;
         f3_q     <= '0;
         word_q   <= '0;
         cnt_q    <= '0;
         loaded_q <= 1'b0;
         mis_q    <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         req_q    <= req_d;
         we_q     <= we_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         mask_q   <= mask_d;
         off_q    <= off_d;
         f3_q     <= f3_d;
         word_q   <= word_d;
         cnt_q    <= cnt_d;
         loaded_q <= loaded_d;
         mis_q    <= mis_d;
         err_q    <= err_d;
      end
   end

   load_align #(.XLEN(XLEN)) u_align (
      .word   (word_q),
      .offset (off_q),
      .funct3 (f3_q),
      .data   (rdata)
   );

   // Gated by rst so the stall drops together with the abandoned request.
   assign mem_stall  = access & ~loaded_q & ~rst;
   assign loaded     = loaded_q;
   assign misaligned = mis_q;
   assign bus_err    = err_q;
   assign dmem_req   = req_q;
   assign dmem_we    = we_q;
   assign dmem_addr  = addr_q;
   assign dmem_wdata = wdata_q;
   assign dmem_mask  = mask_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: transaction-level model of each
// access predicts every cycle's outputs; directed cases pin literal values.
module tb_load_store_unit;

   localparam int TMO = 4;

   logic        clk, rst;
   logic        mem_read, mem_write;
   logic [2:0]  funct3;
   logic [31:0] addr, wdata;
   logic        loaded, mem_stall, misaligned, bus_err;
   logic [31:0] rdata;
   logic        dmem_req, dmem_we, dmem_ack;
   logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
   logic [3:0]  dmem_mask;

   load_store_unit #(.XLEN(32), .ACK_TIMEOUT(TMO)) dut (
      .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write),
      .funct3(funct3), .addr(addr), .wdata(wdata), .loaded(loaded),
      .mem_stall(mem_stall), .rdata(rdata), .misaligned(misaligned),
      .bus_err(bus_err), .dmem_req(dmem_req), .dmem_we(dmem_we),
      .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_mask(dmem_mask),
      .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   bit          chk_en = 0;
   bit          exp_loaded, exp_stall, exp_req, exp_mis, exp_err, exp_we, exp_isload;
   logic [31:0] exp_addr, exp_wdata, exp_rdata;
   logic [3:0]  exp_mask;

   bit          pin_rd_en = 0, pin_st_en = 0;
   logic [31:0] pin_rdata, pin_wdata;
   logic [3:0]  pin_mask;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         chk("loaded", {31'd0, loaded}, {31'd0, exp_loaded});
         chk("mem_stall", {31'd0, mem_stall}, {31'd0, exp_stall});
         chk("dmem_req", {31'd0, dmem_req}, {31'd0, exp_req});
         chk("misaligned", {31'd0, misaligned}, {31'd0, exp_mis});
         chk("bus_err", {31'd0, bus_err}, {31'd0, exp_err});
         if (exp_req) begin
            chk("dmem_we", {31'd0, dmem_we}, {31'd0, exp_we});
            chk("dmem_addr", dmem_addr, exp_addr);
            chk("dmem_mask", {28'd0, dmem_mask}, {28'd0, exp_mask});
            if (exp_we) chk("dmem_wdata", dmem_wdata, exp_wdata);
         end
         if (exp_loaded && exp_isload) chk("rdata", rdata, exp_rdata);
      end
   end

   function automatic int m_size(input logic [2:0] f3, input bit store);
      if (f3 == 3'b000 || (!store && f3 == 3'b100)) return 1;
      if (f3 == 3'b001 || (!store && f3 == 3'b101)) return 2;
      return 4;
   endfunction

   function automatic logic [31:0] m_load(input logic [31:0] w, input int off, input int size,
                                          input bit sgn);
      longint v;
      v = longint'(w >> (8 * off)) & ((64'd1 << (8 * size)) - 64'd1);
      if (sgn && size < 4 && v >= longint'(64'd1 << (8 * size - 1)))
         v = v - longint'(64'd1 << (8 * size));
      return v[31:0];
   endfunction

   function automatic logic [31:0] m_lanes(input logic [31:0] d, input int size);
      if (size == 1) return {24'd0, d[7:0]} * 32'h0101_0101;
      if (size == 2) return {16'd0, d[15:0]} * 32'h0001_0001;
      return d;
   endfunction

   // ack_dly: REQ cycle (1-based) carrying the ack; 0 or > TMO means no ack in time.
   task automatic do_op(input bit wr, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, input int ack_dly, input logic [31:0] ack_word);
      int  size, off, nreq, total;
      bit  algn, err;
      size  = m_size(f3, wr);
      off   = int'(a % 4);
      algn  = (a % size) == 0;
      err   = algn && (ack_dly < 1 || ack_dly > TMO);
      nreq  = !algn ? 0 : (err ? TMO : ack_dly);
      total = algn ? nreq + 1 : 1;
      exp_we     = wr;
      exp_isload = !wr;
      exp_addr   = a & ~32'd3;
      exp_mask   = wr ? 4'(((1 << size) - 1) << off) : 4'hF;
      exp_wdata  = m_lanes(wd, size);
      exp_rdata  = (err || !algn) ? 32'd0 :
                   m_load(ack_word, off, size, size < 4 && f3[2] == 1'b0);
      if (pin_st_en) begin exp_mask = pin_mask; exp_wdata = pin_wdata; end
      if (pin_rd_en) exp_rdata = pin_rdata;
      for (int c = 0; c <= total; c++) begin
         mem_read   = !wr;
         mem_write  = wr;
         funct3     = f3;
         addr       = a;
         wdata      = wd;
         dmem_ack   = 1'b0;
         dmem_rdata = $urandom;
         if (algn && c >= 1 && c <= nreq && c == ack_dly) begin
            dmem_ack   = 1'b1;
            dmem_rdata = ack_word;
         end else if ((c == 0 || c == total) && $urandom_range(0, 2) == 0) begin
            dmem_ack = 1'b1;
         end
         exp_req    = algn && c >= 1 && c <= nreq;
         exp_loaded = (c == total);
         exp_mis    = (c == total) && !algn;
         exp_err    = (c == total) && err;
         exp_stall  = (c != total);
         chk_en     = 1;
         @(posedge clk);
         #1;
      end
      pin_st_en = 0;
      pin_rd_en = 0;
   endtask

   task automatic idle(input int n);
      for (int c = 0; c < n; c++) begin
         mem_read   = 1'b0;
         mem_write  = 1'b0;
         dmem_ack   = ($urandom_range(0, 3) == 0);
         dmem_rdata = $urandom;
         exp_req    = 0;
         exp_loaded = 0;
         exp_mis    = 0;
         exp_err    = 0;
         exp_stall  = 0;
         chk_en     = 1;
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      rst = 1'b1;
      mem_read = 0; mem_write = 0; funct3 = 0; addr = 0; wdata = 0;
      dmem_ack = 0; dmem_rdata = 0;
      #12;
      chk("rst_loaded", {31'd0, loaded}, 32'd0);
      chk("rst_stall", {31'd0, mem_stall}, 32'd0);
      chk("rst_req", {31'd0, dmem_req}, 32'd0);
      chk("rst_rdata", rdata, 32'd0);
      chk("rst_mask", {28'd0, dmem_mask}, 32'd0);
      @(posedge clk);
      #1 rst = 1'b0;
      idle(2);

      pin_rd_en = 1; pin_rdata = 32'hDEAD_BEEF;
      do_op(0, 3'b010, 32'h100, 0, 3, 32'hDEAD_BEEF);
      pin_rd_en = 1; pin_rdata = 32'hFFFF_FF80;
      do_op(0, 3'b000, 32'h103, 0, 1, 32'h80FF_FFFF);
      pin_rd_en = 1; pin_rdata = 32'h0000_0080;
      do_op(0, 3'b100, 32'h103, 0, 2, 32'h80FF_FFFF);
      pin_rd_en = 1; pin_rdata = 32'h0000_BEEF;
      do_op(0, 3'b101, 32'h102, 0, 1, 32'hBEEF_1234);
      pin_st_en = 1; pin_mask = 4'b0010; pin_wdata = 32'hABAB_ABAB;
      do_op(1, 3'b000, 32'h201, 32'h0000_00AB, 1, 0);
      pin_st_en = 1; pin_mask = 4'b1100; pin_wdata = 32'h1234_1234;
      do_op(1, 3'b001, 32'h202, 32'h0000_1234, 2, 0);
      do_op(0, 3'b010, 32'h102, 0, 1, 32'h1111_1111);
      do_op(0, 3'b010, 32'h300, 0, 0, 0);
      do_op(0, 3'b010, 32'h304, 0, 1, 32'h5555_AAAA);
      do_op(1, 3'b010, 32'h308, 32'hCAFE_F00D, 4, 0);
      idle(1);

      // Abandon a request mid-flight with an asynchronous reset.
      chk_en = 0;
      mem_read = 1; mem_write = 0; funct3 = 3'b010; addr = 32'h400; dmem_ack = 0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      chk("req_before_rst", {31'd0, dmem_req}, 32'd1);
      #1 rst = 1'b1;
      #1;
      chk("rst_mid_req", {31'd0, dmem_req}, 32'd0);
      chk("rst_mid_loaded", {31'd0, loaded}, 32'd0);
      chk("rst_mid_stall", {31'd0, mem_stall}, 32'd0);
      mem_read = 0;
      @(posedge clk);
      #1 rst = 1'b0;
      do_op(0, 3'b010, 32'h400, 0, 1, 32'h0BAD_F00D);

      for (int i = 0; i < 200; i++) begin
         do_op(bit'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
               $urandom & 32'h0000_FFFF, $urandom, $urandom_range(0, TMO + 1), $urandom);
         idle($urandom_range(0, 2));
      end

      chk_en = 0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
